// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, ROM latency alignment, stall skid buffer, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds the FETCH_COUNT / SQUASH_COUNT counters.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(32'd4)
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] ADDRESS,
    input  logic [WIDTH-1:0] INSTR,
    input  logic             STALL,
    input  logic             REDIRECT,
    input  logic [WIDTH-1:0] REDIRECT_PC,
    output logic [WIDTH-1:0] IFID_INSTR,
    output logic [WIDTH-1:0] IFID_PC,
    output logic             IFID_VALID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      FETCH_COUNT,
    output logic [31:0]      SQUASH_COUNT
`endif
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(32'd3));

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             req_valid_q, req_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic             ifid_valid_q, ifid_valid_d;

    // Next-state selection with priority redirect > stall > advance.
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (REDIRECT) begin
            pc_d         = REDIRECT_PC & ALIGN_MASK;
            req_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            ifid_valid_d = 1'b0;
        end else if (STALL) begin
            // The word for req_pc_q is only on INSTR during the first stall cycle.
            if (!skid_valid_q && req_valid_q) begin
                skid_d       = INSTR;
                skid_valid_d = 1'b1;
            end else begin
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
            end
        end else begin
            pc_d         = pc_q + PC_STEP;
            req_pc_d     = pc_q;
            req_valid_d  = 1'b1;
            ifid_instr_d = skid_valid_q ? skid_q : INSTR;
            ifid_pc_d    = req_pc_q;
            ifid_valid_d = req_valid_q;
            skid_valid_d = 1'b0;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= {WIDTH{1'b0}};
            req_valid_q  <= 1'b0;
            skid_q       <= {WIDTH{1'b0}};
            skid_valid_q <= 1'b0;
            ifid_instr_q <= {WIDTH{1'b0}};
            ifid_pc_q    <= {WIDTH{1'b0}};
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign ADDRESS    = pc_q;
    assign IFID_INSTR = ifid_instr_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_VALID = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] squash_count_q, squash_count_d;

    // Count real IF/ID loads and redirects that discard live work.
    always_comb begin
        fetch_count_d  = fetch_count_q;
        squash_count_d = squash_count_q;
        if (REDIRECT) begin
            if (req_valid_q || ifid_valid_q) begin
                squash_count_d = squash_count_q + 32'd1;
            end else begin
                squash_count_d = squash_count_q;
            end
        end else if (!STALL && req_valid_q) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter registers, wrapping at 2^32.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_count_q  <= 32'd0;
            squash_count_q <= 32'd0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            squash_count_q <= squash_count_d;
        end
    end

    assign FETCH_COUNT  = fetch_count_q;
    assign SQUASH_COUNT = squash_count_q;
`endif

endmodule
